// File: rtl/ser_frame_sched.sv
// ser_frame_sched: shares the ds_40 serializer between NUM_CH byte requesters (round-robin),
// emitting SYNC / HDR / PAYLOAD frames. Build macro SER_IDLE_FILL_EN keeps the link filled while idle.
module ser_frame_sched #(
    parameter int         NUM_CH      = 4,
    parameter int         BYTE_CYCLES = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'h7E,
    parameter logic [7:0] IDLE_BYTE   = 8'hBC
) (
    input  logic                clock_40,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   req,
    input  logic [8*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]   ack,
    output logic [7:0]          ser_data_in,
    output logic                ser_enable,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SLOT_W = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;

`ifdef SER_IDLE_FILL_EN
    localparam logic IDLE_FILL = 1'b1;
`else
    localparam logic IDLE_FILL = 1'b0;
`endif
    localparam logic [7:0] IDLE_DATA = IDLE_FILL ? IDLE_BYTE : 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [7:0]          r_byte;
    logic [NUM_CH-1:0]   r_ack;
    logic [7:0]          r_data;
    logic                r_en;
    logic                r_busy;
    logic [15:0]         r_frame_cnt;

    state_t              w_state_nx;
    logic [SLOT_W-1:0]   w_slot_nx;
    logic [CH_W-1:0]     w_rr_ptr_nx;
    logic [CH_W-1:0]     w_ch_nx;
    logic [7:0]          w_byte_nx;
    logic [NUM_CH-1:0]   w_ack_nx;
    logic [7:0]          w_data_nx;
    logic                w_en_nx;
    logic                w_busy_nx;
    logic [15:0]         w_frame_cnt_nx;

    logic                w_slot_last;
    logic                w_grant_vld;
    logic                w_grant_take;
    logic [CH_W-1:0]     w_grant_idx;
    logic [CH_W-1:0]     w_cand;
    logic [7:0]          w_grant_byte;

    assign w_slot_last = (r_slot == SLOT_W'(BYTE_CYCLES - 1));

    // Round-robin search starting one past the last winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            if (!w_grant_vld && req[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        w_grant_byte = req_data[{w_grant_idx, 3'b000} +: 8];
    end

    always_comb begin
        w_state_nx     = r_state;
        w_slot_nx      = r_slot + SLOT_W'(1);
        w_rr_ptr_nx    = r_rr_ptr;
        w_ch_nx        = r_ch;
        w_byte_nx      = r_byte;
        w_ack_nx       = '0;
        w_data_nx      = r_data;
        w_en_nx        = r_en;
        w_busy_nx      = r_busy;
        w_frame_cnt_nx = r_frame_cnt;
        w_grant_take   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_slot_nx    = '0;
                w_en_nx      = IDLE_FILL;
                w_data_nx    = IDLE_DATA;
                w_busy_nx    = 1'b0;
                w_grant_take = w_grant_vld;
            end
            ST_SYNC: begin
                if (w_slot_last) begin
                    w_state_nx = ST_HDR;
                    w_slot_nx  = '0;
                    w_data_nx  = {4'hA, 4'(r_ch)};
                end
            end
            ST_HDR: begin
                if (w_slot_last) begin
                    w_state_nx = ST_PAYLOAD;
                    w_slot_nx  = '0;
                    w_data_nx  = r_byte;
                end
            end
            ST_PAYLOAD: begin
                if (w_slot_last) begin
                    w_frame_cnt_nx = r_frame_cnt + 16'd1;
                    w_grant_take   = w_grant_vld;
                    w_state_nx     = ST_IDLE;
                    w_slot_nx      = '0;
                    w_en_nx        = IDLE_FILL;
                    w_data_nx      = IDLE_DATA;
                    w_busy_nx      = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_slot_nx  = '0;
            end
        endcase

        // A grant overrides whatever the state logic chose: the next frame starts at once.
        if (w_grant_take) begin
            w_state_nx            = ST_SYNC;
            w_slot_nx             = '0;
            w_rr_ptr_nx           = w_grant_idx;
            w_ch_nx               = w_grant_idx;
            w_byte_nx             = w_grant_byte;
            w_ack_nx[w_grant_idx] = 1'b1;
            w_en_nx               = 1'b1;
            w_data_nx             = SYNC_BYTE;
            w_busy_nx             = 1'b1;
        end
    end

    always_ff @(posedge clock_40) begin
        if (reset) begin
            // NOTE: these are plain flops, not a memory array, so every one of them is reset.
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_rr_ptr    <= CH_W'(NUM_CH - 1);
            r_ch        <= '0;
            r_byte      <= '0;
            r_ack       <= '0;
            r_data      <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state     <= w_state_nx;
            r_slot      <= w_slot_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_ch        <= w_ch_nx;
            r_byte      <= w_byte_nx;
            r_ack       <= w_ack_nx;
            r_data      <= w_data_nx;
            r_en        <= w_en_nx;
            r_busy      <= w_busy_nx;
            r_frame_cnt <= w_frame_cnt_nx;
        end
    end

    assign ack         = r_ack;
    assign ser_data_in = r_data;
    assign ser_enable  = r_en;
    assign busy        = r_busy;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ser_frame_sched.sv
// Self-checking bench for ser_frame_sched: vector table, directed corner sequences,
// and randomized requesters against a countdown-based frame model.
`timescale 1ns/1ps
module tb_ser_frame_sched;

    localparam int NUM_CH    = 4;
    localparam int BC        = 8;
    localparam int FRAME_LEN = 3 * BC;
`ifdef SER_IDLE_FILL_EN
    localparam logic       IDLE_EN   = 1'b1;
    localparam logic [7:0] IDLE_DATA = 8'hBC;
`else
    localparam logic       IDLE_EN   = 1'b0;
    localparam logic [7:0] IDLE_DATA = 8'h00;
`endif

    logic                clock_40 = 1'b0;
    logic                reset;
    logic [NUM_CH-1:0]   req;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   ack;
    logic [7:0]          ser_data_in;
    logic                ser_enable;
    logic                busy;
    logic [15:0]         frame_cnt;

    always #5 clock_40 = ~clock_40;

    ser_frame_sched #(.NUM_CH(NUM_CH), .BYTE_CYCLES(BC)) dut (
        .clock_40    (clock_40),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .ser_data_in (ser_data_in),
        .ser_enable  (ser_enable),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is 24 cycles of SYNC/HDR/PAYLOAD, counted down from grant.
    int                m_rem = 0;
    int                m_ptr = NUM_CH - 1;
    logic [15:0]       m_cnt = '0;
    logic [NUM_CH-1:0] m_ack = '0;
    logic [7:0]        m_frame [3];
    bit                m_rst_out = 1'b1;

    task automatic model_step();
        int c;
        m_ack = '0;
        if (reset) begin
            m_rem     = 0;
            m_ptr     = NUM_CH - 1;
            m_cnt     = '0;
            m_rst_out = 1'b1;
        end else begin
            m_rst_out = 1'b0;
            if (m_rem == 1) m_cnt = m_cnt + 16'd1;
            if (m_rem <= 1) begin
                m_rem = 0;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_ptr + k) % NUM_CH;
                    if (m_rem == 0 && req[c]) begin
                        m_ptr      = c;
                        m_ack[c]   = 1'b1;
                        m_frame[0] = 8'h7E;
                        m_frame[1] = 8'hA0 | 8'(c);
                        m_frame[2] = req_data[8*c +: 8];
                        m_rem      = FRAME_LEN;
                    end
                end
            end else begin
                m_rem--;
            end
        end
    endtask

    task automatic model_compare();
        logic       en_e;
        logic [7:0] d_e;
        logic       busy_e;
        if (m_rst_out) begin
            en_e = 1'b0; d_e = 8'h00; busy_e = 1'b0;
        end else if (m_rem > 0) begin
            en_e = 1'b1; d_e = m_frame[(FRAME_LEN - m_rem) / BC]; busy_e = 1'b1;
        end else begin
            en_e = IDLE_EN; d_e = IDLE_DATA; busy_e = 1'b0;
        end
        check("model_ack", 32'(ack), 32'(m_ack));
        check("model_en", 32'(ser_enable), 32'(en_e));
        check("model_data", 32'(ser_data_in), 32'(d_e));
        check("model_busy", 32'(busy), 32'(busy_e));
        check("model_cnt", 32'(frame_cnt), 32'(m_cnt));
    endtask

    // Inputs change only at negedges; this waits one rising edge and checks what it produced.
    task automatic step();
        @(negedge clock_40);
        model_step();
        model_compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic                rst;
        logic [NUM_CH-1:0]   req;
        logic [8*NUM_CH-1:0] data;
        int                  n;
        logic [NUM_CH-1:0]   e_ack;
        logic                e_en;
        logic [7:0]          e_data;
        logic                e_busy;
        logic [15:0]         e_cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n_grant;
        int last_c;
        int idx;
        bit got;

        vecs[0] = '{1'b1, 4'hF,    32'h0,        3, 4'b0000, 1'b0,    8'h00,     1'b0, 16'd0};
        vecs[1] = '{1'b0, 4'h0,    32'h0,        4, 4'b0000, IDLE_EN, IDLE_DATA, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 4'b0100, 32'h00BB0000, 1, 4'b0100, 1'b1,    8'h7E,     1'b1, 16'd0};
        vecs[3] = '{1'b0, 4'h0,    32'h0,        7, 4'b0000, 1'b1,    8'h7E,     1'b1, 16'd0};
        vecs[4] = '{1'b0, 4'h0,    32'h0,        8, 4'b0000, 1'b1,    8'hA2,     1'b1, 16'd0};
        vecs[5] = '{1'b0, 4'h0,    32'h0,        8, 4'b0000, 1'b1,    8'hBB,     1'b1, 16'd0};
        vecs[6] = '{1'b0, 4'h0,    32'h0,        2, 4'b0000, IDLE_EN, IDLE_DATA, 1'b0, 16'd1};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;

        // Reset, idle fill and a single frame from ch2.
        for (int i = 0; i < 7; i++) begin
            reset    = vecs[i].rst;
            req      = vecs[i].req;
            req_data = vecs[i].data;
            for (int j = 0; j < vecs[i].n; j++) begin
                step();
                check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
                check($sformatf("vec%0d_en", i), 32'(ser_enable), 32'(vecs[i].e_en));
                check($sformatf("vec%0d_data", i), 32'(ser_data_in), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
                check($sformatf("vec%0d_cnt", i), 32'(frame_cnt), 32'(vecs[i].e_cnt));
            end
        end

        // Fairness: all four requesting, back-to-back frames in order 0,1,2,3,0.
        do_reset();
        req      = '1;
        req_data = 32'h13121110;
        n_grant  = 0;
        last_c   = 0;
        for (int c = 0; c < 5 * FRAME_LEN + 8 && n_grant < 5; c++) begin
            step();
            if (n_grant > 0) check("t3_busy", 32'(busy), 32'd1);
            if (ack != '0) begin
                idx = 0;
                for (int i = NUM_CH - 1; i >= 0; i--) if (ack[i]) idx = i;
                check("t3_order", 32'(idx), 32'(n_grant % NUM_CH));
                if (n_grant > 0) check("t3_gap", 32'(c - last_c), 32'(FRAME_LEN));
                last_c = c;
                n_grant++;
            end
        end
        check("t3_grants", 32'(n_grant), 32'd5);
        req = '0;
        repeat (FRAME_LEN) step();

        // Reset in HDR slot 3 aborts the frame; the held request restarts cleanly.
        do_reset();
        req      = 4'b0010;
        req_data = 32'h00005500;
        got      = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            step();
            if (ack == 4'b0010) got = 1'b1;
        end
        check("t4_first_ack", 32'(got), 32'd1);
        repeat (BC + 3) step();
        check("t4_in_hdr", 32'(ser_data_in), 32'hA1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_rst_ack", 32'(ack), 32'd0);
        check("t4_rst_en", 32'(ser_enable), 32'd0);
        check("t4_rst_data", 32'(ser_data_in), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_cnt", 32'(frame_cnt), 32'd0);
        step();
        check("t4_re_ack", 32'(ack), 32'b0010);
        check("t4_re_sync", 32'(ser_data_in), 32'h7E);
        check("t4_re_en", 32'(ser_enable), 32'd1);
        req = '0;
        repeat (FRAME_LEN) step();
        check("t4_done_cnt", 32'(frame_cnt), 32'd1);

        // Counter wrap from 16'hFFFF.
        do_reset();
        step();
        force dut.r_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.r_frame_cnt;
        check("t6_forced", 32'(frame_cnt), 32'hFFFF);
        req      = 4'b1000;
        req_data = 32'h5A000000;
        step();
        check("t6_ack", 32'(ack), 32'b1000);
        req = '0;
        repeat (FRAME_LEN) step();
        check("t6_wrap_cnt", 32'(frame_cnt), 32'h0000);
        check("t6_idle_en", 32'(ser_enable), 32'(IDLE_EN));
        check("t6_idle_data", 32'(ser_data_in), 32'(IDLE_DATA));
        check("t6_idle_busy", 32'(busy), 32'd0);

        // Random requesters that hold until ack, with rare resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            step();
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_data[8*i +: 8] = 8'($urandom);
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req[i]             = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
